// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//   Bundles every bus signal around the round-robin Wishbone arbiter: the
//   NM master-side request/response lanes and the single downstream
//   32-bit slave bus. Signal names follow the arbiter's own point of view
//   (i_* into the arbiter, o_* out of it).
//
//   Modports:
//     slave  - the arbiter's view: it receives the master requests and the
//              slave response, and drives the routed responses and the
//              muxed slave bus.
//     master - the surrounding system's view (CPU masters plus the memory
//              slave, or a testbench standing in for both): it drives the
//              requests and the slave response and observes everything
//              the arbiter produces.
//
//   Signals (master k occupies slice k of each packed vector):
//     i_m_wb_addr [NM*32]  master addresses
//     i_m_wb_cyc  [NM]     master cycle requests
//     i_m_wb_stb  [NM*4]   master byte-lane strobes (bit 3 = lane 00)
//     i_m_wb_we   [NM]     master write enables
//     i_m_wb_dat  [NM*32]  master write data
//     o_m_wb_dat  [32]     read data shared by all masters
//     o_m_wb_ack  [NM]     per-master ack
//     o_m_wb_err  [NM]     per-master err
//     o_wb_addr   [32]     slave address
//     o_wb_cyc             slave cycle
//     o_wb_stb    [4]      slave byte-lane strobes
//     o_wb_we              slave write enable
//     o_wb_dat    [32]     slave write data
//     i_wb_dat    [32]     slave read data
//     i_wb_ack             slave ack
//     i_wb_err             slave err
//     o_grant     [NM]     one-hot current grant, zero when idle
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int NM = 3
);

  logic [NM*32-1:0] i_m_wb_addr;
  logic [NM-1:0]    i_m_wb_cyc;
  logic [NM*4-1:0]  i_m_wb_stb;
  logic [NM-1:0]    i_m_wb_we;
  logic [NM*32-1:0] i_m_wb_dat;
  logic [31:0]      o_m_wb_dat;
  logic [NM-1:0]    o_m_wb_ack;
  logic [NM-1:0]    o_m_wb_err;

  logic [31:0]      o_wb_addr;
  logic             o_wb_cyc;
  logic [3:0]       o_wb_stb;
  logic             o_wb_we;
  logic [31:0]      o_wb_dat;
  logic [31:0]      i_wb_dat;
  logic             i_wb_ack;
  logic             i_wb_err;

  logic [NM-1:0]    o_grant;

  modport slave (
    input  i_m_wb_addr, i_m_wb_cyc, i_m_wb_stb, i_m_wb_we, i_m_wb_dat,
    input  i_wb_dat, i_wb_ack, i_wb_err,
    output o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
    output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
    output o_grant
  );

  modport master (
    output i_m_wb_addr, i_m_wb_cyc, i_m_wb_stb, i_m_wb_we, i_m_wb_dat,
    output i_wb_dat, i_wb_ack, i_wb_err,
    input  o_m_wb_dat, o_m_wb_ack, o_m_wb_err,
    input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
    input  o_grant
  );

endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Round-robin Wishbone arbiter sitting directly below the CPU memory
//   masters (0 = instruction fetch, 1 = load unit, 2 = store unit). One
//   master at a time owns the single 32-bit system bus; the slave's ack,
//   err and read data are routed back to that master only. A strobed
//   access that waits TIMEOUT cycles without any slave response is
//   terminated by the arbiter with an err to the owning master.
//
//   Parameters:
//     NM      number of masters
//     TIMEOUT cycles a strobed access may wait before a bus-timeout err;
//             0 disables the timeout
//     TW      width of the timeout counter (TIMEOUT < 2**TW)
//
//   Ports:
//     i_clk    clock, all logic on the rising edge
//     i_reset  synchronous active-high reset
//     bus      wb_arbiter_if.slave - master lanes, slave bus and o_grant
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NM      = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  wb_arbiter_if.slave  bus
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [NM-1:0]  grant;
  logic [NM-1:0]  grant_next;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  gidx_next;
  logic [IW-1:0]  rr;
  logic [IW-1:0]  rr_next;
  logic [TW-1:0]  tcount;
  logic [TW-1:0]  tcount_next;

  logic           found;
  logic [IW-1:0]  pick;

  logic [31:0]    sel_addr;
  logic [31:0]    sel_dat;
  logic           sel_cyc;
  logic           sel_we;
  logic [3:0]     sel_stb;
  logic           strobed;
  logic           timeout_hit;

  logic [31:0]    wb_addr;
  logic           wb_cyc;
  logic [3:0]     wb_stb;
  logic           wb_we;
  logic [31:0]    wb_dat;
  logic [NM-1:0]  m_ack;
  logic [NM-1:0]  m_err;

  // Lanes of the currently granted master. A compare-and-select loop keeps
  // the mux free of out-of-range slices when NM is not a power of two.
  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    sel_cyc  = 1'b0;
    sel_we   = 1'b0;
    sel_stb  = '0;
    for (int k = 0; k < NM; k++) begin
      if (gidx == IW'(k)) begin
        sel_addr = bus.i_m_wb_addr[32*k +: 32];
        sel_dat  = bus.i_m_wb_dat[32*k +: 32];
        sel_cyc  = bus.i_m_wb_cyc[k];
        sel_we   = bus.i_m_wb_we[k];
        sel_stb  = bus.i_m_wb_stb[4*k +: 4];
      end
    end
  end

  // Round-robin search: first requester at or above the rr pointer,
  // wrapping modulo NM.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NM; i++) begin
      idx = int'(rr) + i;
      if (idx >= NM) begin
        idx = idx - NM;
      end
      if (!found && bus.i_m_wb_cyc[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // A slave response in the deadline cycle takes priority, so the timeout
  // only fires when neither ack nor err is present.
  assign strobed     = sel_cyc && (sel_stb != 4'b0000);
  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && strobed &&
                       !bus.i_wb_ack && !bus.i_wb_err &&
                       (tcount == TW'(TIMEOUT));

  // State register together with the grant, rr pointer and wait counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr     <= '0;
      tcount <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      gidx   <= gidx_next;
      rr     <= rr_next;
      tcount <= tcount_next;
    end
  end

  // Next-state logic. Leaving BUSY always passes through IDLE, which gives
  // the mandatory dead cycle between two owners.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    gidx_next   = gidx;
    rr_next     = rr;
    tcount_next = '0;
    case (state)
      IDLE: begin
        grant_next = '0;
        if (found) begin
          state_next = BUSY;
          gidx_next  = pick;
          grant_next = NM'(1) << pick;
        end
      end
      BUSY: begin
        if (!sel_cyc) begin
          state_next = IDLE;
          grant_next = '0;
          rr_next    = (gidx == IW'(NM-1)) ? '0 : gidx + 1'b1;
        end else if ((TIMEOUT != 0) && strobed && !bus.i_wb_ack &&
                     !bus.i_wb_err && !timeout_hit) begin
          tcount_next = tcount + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Output logic. In BUSY the slave bus is a live copy of the owner's lanes,
  // so the slave cycle drops in the very cycle the owner drops cyc. The
  // timeout cycle suppresses cyc/stb so the stalled access is abandoned.
  always_comb begin
    wb_addr = '0;
    wb_cyc  = 1'b0;
    wb_stb  = '0;
    wb_we   = 1'b0;
    wb_dat  = '0;
    m_ack   = '0;
    m_err   = '0;
    if (state == BUSY) begin
      wb_addr = sel_addr;
      wb_cyc  = sel_cyc && !timeout_hit;
      wb_stb  = timeout_hit ? 4'b0000 : sel_stb;
      wb_we   = sel_we;
      wb_dat  = sel_dat;
      m_ack   = grant & {NM{bus.i_wb_ack}};
      m_err   = grant & {NM{bus.i_wb_err | timeout_hit}};
    end
  end

  assign bus.o_wb_addr  = wb_addr;
  assign bus.o_wb_cyc   = wb_cyc;
  assign bus.o_wb_stb   = wb_stb;
  assign bus.o_wb_we    = wb_we;
  assign bus.o_wb_dat   = wb_dat;
  assign bus.o_m_wb_ack = m_ack;
  assign bus.o_m_wb_err = m_err;
  assign bus.o_m_wb_dat = bus.i_wb_dat;
  assign bus.o_grant    = grant;

  // Grant integrity: empty while idle, exactly one owner while busy.
  a_idle_no_grant: assert property (@(posedge i_clk) disable iff (i_reset)
    (state == IDLE) |-> (grant == '0));
  a_busy_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
    (state == BUSY) |-> $onehot(grant));

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter (NM=3, TIMEOUT=4). A behavioural
//   model tracks who owns the bus, the round-robin start point and how long
//   the current strobed access has waited; a compare process checks every
//   DUT output against it on each falling edge. Directed sequences pin the
//   model with literal expectations, then a long randomized phase exercises
//   requests, drops, strobe gaps, slave responses and resets.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int NM      = 3;
  localparam int TIMEOUT = 4;
  localparam int TW      = 8;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  wb_arbiter_if #(.NM(NM)) bus ();

  wb_arbiter #(
    .NM      (NM),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Shadow copies of the inputs; pushed onto the bus just after a rising
  // edge so they are stable for a whole cycle.
  logic              s_reset;
  logic [NM-1:0]     s_cyc;
  logic [NM-1:0]     s_we;
  logic [3:0]        s_stb  [NM];
  logic [31:0]       s_addr [NM];
  logic [31:0]       s_dat  [NM];
  logic              s_ack;
  logic              s_err;
  logic [31:0]       s_rdat;

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  // Model state: owner (-1 = nobody), round-robin start, cycles waited.
  int m_owner = -1;
  int m_rr    = 0;
  int m_wait  = 0;

  task automatic pushInputs();
    i_reset        = s_reset;
    bus.i_m_wb_cyc = s_cyc;
    bus.i_m_wb_we  = s_we;
    for (int k = 0; k < NM; k++) begin
      bus.i_m_wb_stb[4*k +: 4]   = s_stb[k];
      bus.i_m_wb_addr[32*k +: 32] = s_addr[k];
      bus.i_m_wb_dat[32*k +: 32]  = s_dat[k];
    end
    bus.i_wb_ack = s_ack;
    bus.i_wb_err = s_err;
    bus.i_wb_dat = s_rdat;
  endtask

  // One cycle: apply the shadow inputs after the rising edge and return at
  // the following falling edge, where outputs are sampled.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    pushInputs();
    @(negedge i_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic logic deadlineNow();
    logic [3:0] stb;
    if (m_owner < 0 || TIMEOUT == 0) return 1'b0;
    stb = bus.i_m_wb_stb[4*m_owner +: 4];
    return bus.i_m_wb_cyc[m_owner] && (stb != 4'b0000) &&
           (m_wait == TIMEOUT) && !bus.i_wb_ack && !bus.i_wb_err;
  endfunction

  // Model update on each rising edge from the inputs held during the cycle.
  always @(posedge i_clk) begin : model_proc
    int   nown;
    int   nrr;
    int   nwait;
    int   k;
    logic dl;
    logic [3:0] stb;
    nown  = m_owner;
    nrr   = m_rr;
    nwait = m_wait;
    dl    = deadlineNow();
    if (i_reset) begin
      nown  = -1;
      nrr   = 0;
      nwait = 0;
    end else if (m_owner < 0) begin
      nwait = 0;
      for (int i = 0; i < NM; i++) begin
        k = (m_rr + i) % NM;
        if (nown < 0 && bus.i_m_wb_cyc[k]) nown = k;
      end
    end else if (!bus.i_m_wb_cyc[m_owner]) begin
      nrr   = (m_owner + 1) % NM;
      nown  = -1;
      nwait = 0;
    end else begin
      stb = bus.i_m_wb_stb[4*m_owner +: 4];
      if (stb != 4'b0000 && !bus.i_wb_ack && !bus.i_wb_err && !dl)
        nwait = m_wait + 1;
      else
        nwait = 0;
    end
    m_owner <= nown;
    m_rr    <= nrr;
    m_wait  <= nwait;
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge i_clk) begin : compare_proc
    logic [NM-1:0] eg;
    logic [NM-1:0] ea;
    logic [NM-1:0] ee;
    logic [31:0]   eaddr;
    logic [31:0]   edat;
    logic [3:0]    estb;
    logic          ecyc;
    logic          ewe;
    logic          dl;
    eg = '0; ea = '0; ee = '0; eaddr = '0; edat = '0;
    estb = '0; ecyc = 1'b0; ewe = 1'b0;
    if (checking) begin
      if (m_owner >= 0) begin
        dl    = deadlineNow();
        eg    = NM'(1) << m_owner;
        eaddr = bus.i_m_wb_addr[32*m_owner +: 32];
        edat  = bus.i_m_wb_dat[32*m_owner +: 32];
        ewe   = bus.i_m_wb_we[m_owner];
        ecyc  = bus.i_m_wb_cyc[m_owner] && !dl;
        estb  = dl ? 4'b0000 : bus.i_m_wb_stb[4*m_owner +: 4];
        ea    = bus.i_wb_ack ? eg : '0;
        ee    = (bus.i_wb_err || dl) ? eg : '0;
      end
      checkOutput("model grant",  32'(bus.o_grant),    32'(eg));
      checkOutput("model cyc",    32'(bus.o_wb_cyc),   32'(ecyc));
      checkOutput("model stb",    32'(bus.o_wb_stb),   32'(estb));
      checkOutput("model addr",   bus.o_wb_addr,       eaddr);
      checkOutput("model we",     32'(bus.o_wb_we),    32'(ewe));
      checkOutput("model wdat",   bus.o_wb_dat,        edat);
      checkOutput("model ack",    32'(bus.o_m_wb_ack), 32'(ea));
      checkOutput("model err",    32'(bus.o_m_wb_err), 32'(ee));
      checkOutput("model rdat",   bus.o_m_wb_dat,      bus.i_wb_dat);
    end
  end

  initial begin
    s_reset = 1'b1;
    s_cyc   = '0;
    s_we    = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rdat  = '0;
    for (int k = 0; k < NM; k++) begin
      s_stb[k]  = '0;
      s_addr[k] = '0;
      s_dat[k]  = '0;
    end
    pushInputs();

    // Reset
    applyStimulus();
    checking = 1'b1;
    applyStimulus();
    checkOutput("reset grant", 32'(bus.o_grant), 32'h0);
    checkOutput("reset cyc",   32'(bus.o_wb_cyc), 32'h0);
    checkOutput("reset ack",   32'(bus.o_m_wb_ack), 32'h0);
    s_reset = 1'b0;
    applyStimulus();

    // Single store from master 2, ack in the 3rd BUSY cycle
    s_cyc     = 3'b100;
    s_stb[2]  = 4'b0100;
    s_we[2]   = 1'b1;
    s_addr[2] = 32'h0000_0104;
    s_dat[2]  = 32'h5A5A_5A5A;
    applyStimulus();
    checkOutput("store arb latency", 32'(bus.o_grant), 32'h0);
    applyStimulus();
    checkOutput("store grant", 32'(bus.o_grant), 32'h4);
    checkOutput("store addr",  bus.o_wb_addr, 32'h0000_0104);
    checkOutput("store stb",   32'(bus.o_wb_stb), 32'h4);
    checkOutput("store dat",   bus.o_wb_dat, 32'h5A5A_5A5A);
    applyStimulus();
    checkOutput("store no early ack", 32'(bus.o_m_wb_ack), 32'h0);
    s_ack = 1'b1;
    applyStimulus();
    checkOutput("store ack", 32'(bus.o_m_wb_ack), 32'h4);
    s_ack = 1'b0;
    s_cyc = 3'b000;
    s_stb[2] = 4'b0000;
    s_we[2]  = 1'b0;
    applyStimulus();
    checkOutput("store release cyc", 32'(bus.o_wb_cyc), 32'h0);
    applyStimulus();
    checkOutput("store idle", 32'(bus.o_grant), 32'h0);

    // Round-robin over two rounds; rr wraps from 2 back to 0
    for (int r = 0; r < 2; r++) begin
      s_cyc = 3'b111;
      for (int k = 0; k < NM; k++) s_stb[k] = 4'hF;
      for (int k = 0; k < NM; k++) begin
        applyStimulus();
        checkOutput("rr dead cycle", 32'(bus.o_grant), 32'h0);
        s_ack = 1'b1;
        applyStimulus();
        checkOutput("rr grant order", 32'(bus.o_grant), 32'(1 << k));
        checkOutput("rr ack route",   32'(bus.o_m_wb_ack), 32'(1 << k));
        s_ack = 1'b0;
        s_cyc[k] = 1'b0;
        applyStimulus();
      end
    end

    // Read routing to master 1 while 0 and 2 wait
    s_cyc     = 3'b010;
    s_we      = 3'b000;
    s_addr[1] = 32'h0000_0200;
    applyStimulus();
    s_cyc = 3'b111;
    applyStimulus();
    checkOutput("read grant", 32'(bus.o_grant), 32'h2);
    checkOutput("read addr",  bus.o_wb_addr, 32'h0000_0200);
    s_ack  = 1'b1;
    s_rdat = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("read data", bus.o_m_wb_dat, 32'hDEAD_BEEF);
    checkOutput("read ack",  32'(bus.o_m_wb_ack), 32'h2);
    s_ack = 1'b0;
    s_cyc = 3'b000;
    applyStimulus();

    // Timeout on master 0, then ack exactly at the deadline
    s_cyc    = 3'b001;
    s_stb[0] = 4'b0001;
    applyStimulus();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus();
      checkOutput("timeout err", 32'(bus.o_m_wb_err), (i % 5 == 0) ? 32'h1 : 32'h0);
      checkOutput("timeout cyc", 32'(bus.o_wb_cyc),   (i % 5 == 0) ? 32'h0 : 32'h1);
    end
    for (int i = 1; i <= 4; i++) applyStimulus();
    s_ack = 1'b1;
    applyStimulus();
    checkOutput("deadline ack", 32'(bus.o_m_wb_ack), 32'h1);
    checkOutput("deadline err", 32'(bus.o_m_wb_err), 32'h0);
    checkOutput("deadline cyc", 32'(bus.o_wb_cyc),   32'h1);
    s_ack = 1'b0;
    s_cyc = 3'b000;
    applyStimulus();

    // Reset while master 2 waits for ack
    s_cyc    = 3'b100;
    s_stb[2] = 4'b0100;
    applyStimulus();
    s_cyc = 3'b110;
    applyStimulus();
    checkOutput("pre-reset grant", 32'(bus.o_grant), 32'h4);
    s_reset = 1'b1;
    s_ack   = 1'b1;
    applyStimulus();
    s_reset = 1'b0;
    s_ack   = 1'b0;
    applyStimulus();
    checkOutput("post-reset grant", 32'(bus.o_grant), 32'h0);
    checkOutput("post-reset cyc",   32'(bus.o_wb_cyc), 32'h0);
    checkOutput("post-reset ack",   32'(bus.o_m_wb_ack), 32'h0);
    checkOutput("post-reset err",   32'(bus.o_m_wb_err), 32'h0);
    applyStimulus();
    checkOutput("post-reset rearb", 32'(bus.o_grant), 32'h2);
    s_cyc = 3'b000;
    applyStimulus();
    applyStimulus();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_reset = ($urandom_range(0, 255) == 0);
      for (int k = 0; k < NM; k++) begin
        if (!s_cyc[k])
          s_cyc[k] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 5) == 0)
          s_cyc[k] = 1'b0;
        s_stb[k]  = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        s_we[k]   = 1'($urandom);
        s_addr[k] = $urandom;
        s_dat[k]  = $urandom;
      end
      s_ack  = ($urandom_range(0, 9) < 3);
      s_err  = ($urandom_range(0, 11) == 0);
      s_rdat = $urandom;
      applyStimulus();
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone arbiter that sits directly downstream of the CPU memory masters: instruction fetch, load unit and store unit.
- Multiplexes NM masters onto the single 32-bit system bus.
- Routes the slave's ack, err and read data back to the granted master only.
- Generates a bus-timeout error when the slave does not respond.
- Uses the codebase's 4-bit byte-lane o_wb_stb convention: bit 3 = byte at addr[1:0]=00; any nonzero stb means a strobe is active.

Parameters:
- NM, 3, number of masters (index 0 = fetch, 1 = load, 2 = store).
- TIMEOUT, 255, cycles a strobed access may wait for ack/err before the arbiter returns err. 0 disables the timeout.
- TW, 8, width of the timeout counter. Must satisfy TIMEOUT < 2**TW.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_m_wb_addr  in  NM*32  master addresses, master k at [32k+31:32k].
- i_m_wb_cyc  in  NM  master cycle requests.
- i_m_wb_stb  in  NM*4  master byte-lane strobes.
- i_m_wb_we  in  NM  master write enables.
- i_m_wb_dat  in  NM*32  master write data.
- o_m_wb_dat  out  32  read data, shared by all masters (valid only with that master's ack).
- o_m_wb_ack  out  NM  per-master ack.
- o_m_wb_err  out  NM  per-master err.
- o_wb_addr  out  32  slave address.
- o_wb_cyc  out  1  slave cycle.
- o_wb_stb  out  4  slave byte-lane strobes.
- o_wb_we  out  1  slave write enable.
- o_wb_dat  out  32  slave write data.
- i_wb_dat  in  32  slave read data.
- i_wb_ack  in  1  slave ack.
- i_wb_err  in  1  slave err.
- o_grant  out  NM  one-hot current grant (debug/verification); all zero when idle.

Behaviour:
- Reset: state=IDLE, grant=0, rr pointer=0, timeout counter=0. All slave outputs 0; o_m_wb_ack=0, o_m_wb_err=0.
- State IDLE:
  - Slave outputs forced 0.
  - If any i_m_wb_cyc is high, register a grant to the first requesting master found searching from rr pointer upward, modulo NM. Enter BUSY next cycle (1-cycle arbitration latency).
- State BUSY, master g granted:
  - Slave outputs are combinational copies of master g's addr/cyc/stb/we/dat.
  - o_m_wb_ack[g] = i_wb_ack and o_m_wb_err[g] = i_wb_err, combinational.
  - All other masters' ack/err are 0.
  - Non-granted masters see nothing and simply wait with cyc high.
- Release:
  - When i_m_wb_cyc[g] is sampled low in BUSY, go to IDLE next cycle and set rr pointer = (g+1) mod NM.
  - The slave cycle drops in the same cycle master g drops cyc, since the outputs are combinational copies.
  - The IDLE cycle between grants is mandatory (one dead cycle), even if other masters are waiting.
- Grant hold: grant is held across multiple accesses for as long as master g keeps cyc high. No preemption.
- Timeout:
  - Counter increments each BUSY cycle with o_wb_cyc && |o_wb_stb && !i_wb_ack && !i_wb_err.
  - Counter clears on ack, on err, when stb=0, and in IDLE.
  - When the counter equals TIMEOUT, o_m_wb_err[g]=1 for exactly that cycle; o_wb_cyc and o_wb_stb are forced 0 that cycle; the counter clears.
  - Grant is kept; master g decides whether to drop cyc.
- Simultaneous events:
  - Slave ack or err in the same cycle the counter reaches TIMEOUT: the slave response wins and no timeout err is generated.
  - ack and err together from the slave: both are passed through unchanged.
- A request with cyc high but stb=0 holds the grant; the counter does not run.
- Reset mid-operation: next cycle is IDLE with all outputs 0, regardless of the slave's ack; pending masters are re-arbitrated from rr=0.
- Width rules:
  - o_m_wb_dat = i_wb_dat, unmodified; byte extraction and sign extension belong to the load unit.
  - Write data and stb pass through unmodified; lane replication is done by the store unit.

Test Plan:
- Single store: master 2 raises cyc, stb=4'b0100, we=1, addr=0x104, dat=0x5A5A5A5A. Required: o_grant=3'b100 one cycle later; slave sees the same values; slave ack in the 3rd BUSY cycle → o_m_wb_ack=3'b100 that cycle only; master drops cyc → IDLE.
- Round-robin: masters 0, 1 and 2 all hold cyc, each dropping it after one ack. Required grant order 0, 1, 2, with one IDLE cycle between grants. Re-raising all three then gives order 0, 1, 2 again (rr wraps from 2 to 0).
- Read routing: master 1 reads addr 0x200; slave returns i_wb_dat=0xDEADBEEF with ack. Required: o_m_wb_dat=0xDEADBEEF, o_m_wb_ack=3'b010; masters 0 and 2 see no ack while their cyc is held high.
- Timeout: TIMEOUT=4; master 0 strobes and the slave never responds. Required: o_m_wb_err=3'b001 in the 5th strobed BUSY cycle with o_wb_cyc=0 that cycle; the next strobe restarts the count.
- Ack at deadline: slave ack arrives in the same cycle the counter reaches TIMEOUT. Required: ack passed through, no err.
- Reset mid-cycle: assert i_reset while master 2 is granted and awaiting ack. Required: next cycle o_grant=0, o_wb_cyc=0, all ack/err 0; with cyc still high on masters 1 and 2, the grant goes to master 1 (search from rr=0).
